// File: rtl/pixel_sensor_ctrl.sv
// pixel_sensor_ctrl: frame sequencer for the pixel array.
// A frame runs ERASE -> EXPOSE -> CONVERT -> READ (one row at a time). Each
// row is captured from row_data into a one-entry output slot.
// Optional feature: define PIXEL_CTRL_FRAME_CNT_EN to add the 16-bit
// frame_count output (wraps from 0xFFFF to 0).
//
// Handshake: out_valid/out_data/out_row form a valid/ready source. A beat
// transfers on a cycle where out_valid && out_ready. Once out_valid is high,
// out_data/out_row stay stable until that transfer. A row is only captured
// when the slot is free (!out_valid || out_ready). Otherwise the row select
// is held, which stalls readout instead of dropping data.
module pixel_sensor_ctrl #(
  parameter int PIXEL_ARRAY_WIDTH  = 2,
  parameter int PIXEL_ARRAY_HEIGHT = 2,
  parameter int C_ERASE            = 5,
  parameter int C_CONVERT          = 255,
  parameter int C_READ_ROW         = 5,
  parameter int EXPOSE_W           = 8
) (
  input  logic                                    clk,
  input  logic                                    reset,
  input  logic                                    start,
  input  logic                                    continuous,
  input  logic [EXPOSE_W-1:0]                     expose_time,
  output logic                                    ERASE,
  output logic                                    EXPOSE,
  output logic                                    CONVERT,
  output logic [7:0]                              COUNTER,
  output logic [PIXEL_ARRAY_HEIGHT-1:0]           READ,
  input  logic [PIXEL_ARRAY_WIDTH*8-1:0]          row_data,
  output logic [PIXEL_ARRAY_WIDTH*8-1:0]          out_data,
  output logic [(PIXEL_ARRAY_HEIGHT > 1 ? $clog2(PIXEL_ARRAY_HEIGHT) : 1)-1:0] out_row,
  output logic                                    out_valid,
  input  logic                                    out_ready,
  output logic                                    busy,
  output logic                                    frame_done,
`ifdef PIXEL_CTRL_FRAME_CNT_EN
  output logic [15:0]                             frame_count,
`endif
  output logic [2:0]                              state_dbg
);

  localparam int ROW_W   = (PIXEL_ARRAY_HEIGHT > 1) ? $clog2(PIXEL_ARRAY_HEIGHT) : 1;
  // Phase counter covers ERASE, EXPOSE and per-row READ dwell; CONVERT uses COUNTER itself.
  localparam int CNT_MAX = (C_ERASE > C_READ_ROW) ?
                           ((C_ERASE > (2**EXPOSE_W)) ? C_ERASE : (2**EXPOSE_W)) :
                           ((C_READ_ROW > (2**EXPOSE_W)) ? C_READ_ROW : (2**EXPOSE_W));
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [PIXEL_ARRAY_HEIGHT-1:0] ROW0_SEL = PIXEL_ARRAY_HEIGHT'(1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ERASE   = 3'd1,
    S_EXPOSE  = 3'd2,
    S_CONVERT = 3'd3,
    S_READ    = 3'd4
  } state_t;

  state_t              state;
  logic [CNT_W-1:0]    cnt;
  logic [EXPOSE_W-1:0] exp_lat;
  logic [ROW_W-1:0]    row;
  logic                slot_free;
  logic                row_last_cycle;
  logic                capture;
  logic                last_capture;

  assign state_dbg      = state;
  assign slot_free      = !out_valid || out_ready;
  assign row_last_cycle = (state == S_READ) && (cnt == CNT_W'(C_READ_ROW - 1));
  assign capture        = row_last_cycle && slot_free;
  assign last_capture   = capture && (row == ROW_W'(PIXEL_ARRAY_HEIGHT - 1));

  // Frame sequencer: state, phase timing and registered control outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      cnt        <= '0;
      exp_lat    <= '0;
      row        <= '0;
      ERASE      <= 1'b0;
      EXPOSE     <= 1'b0;
      CONVERT    <= 1'b0;
      COUNTER    <= 8'd0;
      READ       <= '0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            state   <= S_ERASE;
            ERASE   <= 1'b1;
            busy    <= 1'b1;
            exp_lat <= expose_time;
            cnt     <= '0;
          end
        end
        S_ERASE: begin
          if (cnt == CNT_W'(C_ERASE - 1)) begin
            ERASE <= 1'b0;
            cnt   <= '0;
            if (exp_lat == '0) begin
              state   <= S_CONVERT;
              CONVERT <= 1'b1;
              COUNTER <= 8'd0;
            end else begin
              state  <= S_EXPOSE;
              EXPOSE <= 1'b1;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        S_EXPOSE: begin
          if ((cnt + CNT_W'(1)) == CNT_W'(exp_lat)) begin
            state   <= S_CONVERT;
            EXPOSE  <= 1'b0;
            CONVERT <= 1'b1;
            COUNTER <= 8'd0;
            cnt     <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        S_CONVERT: begin
          if (COUNTER == 8'(C_CONVERT - 1)) begin
            state   <= S_READ;
            CONVERT <= 1'b0;
            COUNTER <= 8'd0;
            READ    <= ROW0_SEL;
            row     <= '0;
            cnt     <= '0;
          end else begin
            COUNTER <= COUNTER + 8'd1;
          end
        end
        S_READ: begin
          if (capture) begin
            cnt <= '0;
            if (last_capture) begin
              frame_done <= 1'b1;
              READ       <= '0;
              row        <= '0;
              if (continuous) begin
                state   <= S_ERASE;
                ERASE   <= 1'b1;
                exp_lat <= expose_time;
              end else begin
                state <= S_IDLE;
                busy  <= 1'b0;
              end
            end else begin
              row  <= row + ROW_W'(1);
              READ <= ROW0_SEL << (row + ROW_W'(1));
            end
          end else if (!row_last_cycle) begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          state   <= S_IDLE;
          ERASE   <= 1'b0;
          EXPOSE  <= 1'b0;
          CONVERT <= 1'b0;
          COUNTER <= 8'd0;
          READ    <= '0;
          busy    <= 1'b0;
          cnt     <= '0;
        end
      endcase
    end
  end

  // One-entry output slot: capture wins over a same-cycle acceptance.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_row   <= '0;
    end else if (capture) begin
      out_valid <= 1'b1;
      out_data  <= row_data;
      out_row   <= row;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef PIXEL_CTRL_FRAME_CNT_EN
  // Completed-frame counter, updated together with frame_done.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frame_count <= 16'd0;
    end else if (last_capture) begin
      frame_count <= frame_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pixel_sensor_ctrl.sv
// tb_pixel_sensor_ctrl: directed sequence with randomized data, exposure and
// back-pressure, checked every cycle against a timeline model of a frame.
module tb_pixel_sensor_ctrl;

  localparam int W   = 2;
  localparam int H   = 2;
  localparam int CE  = 5;
  localparam int CC  = 255;
  localparam int CRR = 5;
  localparam int EW  = 8;
  localparam int DW  = W * 8;
  localparam int RW  = (H > 1) ? $clog2(H) : 1;

  // ---------------- clock / reset / DUT ----------------
  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          continuous = 1'b0;
  logic          out_ready = 1'b1;
  logic [EW-1:0] expose_time = '0;
  logic          ERASE, EXPOSE, CONVERT;
  logic [7:0]    COUNTER;
  logic [H-1:0]  READ;
  logic [DW-1:0] row_data, out_data;
  logic [RW-1:0] out_row;
  logic          out_valid, busy, frame_done;
  logic [2:0]    state_dbg;
`ifdef PIXEL_CTRL_FRAME_CNT_EN
  logic [15:0]   frame_count;
`endif

  always #5 clk = ~clk;

  pixel_sensor_ctrl #(
    .PIXEL_ARRAY_WIDTH(W), .PIXEL_ARRAY_HEIGHT(H), .C_ERASE(CE),
    .C_CONVERT(CC), .C_READ_ROW(CRR), .EXPOSE_W(EW)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .continuous(continuous),
    .expose_time(expose_time), .ERASE(ERASE), .EXPOSE(EXPOSE),
    .CONVERT(CONVERT), .COUNTER(COUNTER), .READ(READ), .row_data(row_data),
    .out_data(out_data), .out_row(out_row), .out_valid(out_valid),
    .out_ready(out_ready), .busy(busy), .frame_done(frame_done),
`ifdef PIXEL_CTRL_FRAME_CNT_EN
    .frame_count(frame_count),
`endif
    .state_dbg(state_dbg)
  );

  // Pixel array stand-in: the selected row drives DATA_OUT.
  logic [DW-1:0] pix [H];
  always_comb begin
    row_data = '0;
    for (int i = 0; i < H; i++) if (READ[i]) row_data = pix[i];
  end

  // ---------------- bookkeeping ----------------
  int n_chk = 0, n_err = 0, cyc = 0;
  int n_fd_seen = 0, n_expose_seen = 0, erase_rise_cyc = 0, fd_cyc = 0;
  logic prev_erase = 1'b0;
  bit rnd_ready = 0, rnd_start = 0;

  // ---------------- reference model ----------------
  // A frame is a timeline: t counts cycles from the first ERASE cycle through
  // the end of CONVERT; READ then walks rows, each dwelling CRR cycles plus any
  // stall while the output slot is occupied.
  bit            m_busy, m_rd, m_ov, m_fd;
  int            m_t, m_e, m_row, m_dwell, m_frames, m_orow;
  logic [DW-1:0] m_od;
  logic [RW+DW-1:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s at cycle %0d: observed %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_rd = 0; m_ov = 0; m_fd = 0;
    m_t = 0; m_e = 0; m_row = 0; m_dwell = 0; m_frames = 0; m_orow = 0;
    m_od = '0;
    exp_q.delete();
  endtask

  task automatic model_edge();
    bit cap, slot_free;
    int cap_row;
    cap = 0; cap_row = 0;
    slot_free = !m_ov || out_ready;
    m_fd = 0;
    if (reset) begin
      model_reset();
      return;
    end
    if (!m_busy) begin
      if (start) begin
        m_busy = 1; m_rd = 0; m_t = 0; m_e = int'(expose_time);
      end
    end else if (!m_rd) begin
      m_t++;
      if (m_t == CE + m_e + CC) begin
        m_rd = 1; m_row = 0; m_dwell = 1;
      end
    end else if (m_dwell == CRR && slot_free) begin
      cap = 1; cap_row = m_row;
      if (m_row == H - 1) begin
        m_fd = 1; m_frames++;
        if (continuous) begin
          m_rd = 0; m_t = 0; m_e = int'(expose_time);
        end else begin
          m_busy = 0;
        end
      end else begin
        m_row++; m_dwell = 1;
      end
    end else if (m_dwell < CRR) begin
      m_dwell++;
    end
    if (cap) begin
      m_ov = 1; m_od = pix[cap_row]; m_orow = cap_row;
      exp_q.push_back({RW'(cap_row), pix[cap_row]});
    end else if (out_ready) begin
      m_ov = 0;
    end
  endtask

  task automatic check_outputs();
    bit e_erase, e_expose, e_convert;
    int e_counter, e_read;
    e_erase   = m_busy && !m_rd && (m_t < CE);
    e_expose  = m_busy && !m_rd && (m_t >= CE) && (m_t < CE + m_e);
    e_convert = m_busy && !m_rd && (m_t >= CE + m_e);
    e_counter = e_convert ? (m_t - CE - m_e) : 0;
    e_read    = (m_busy && m_rd) ? (1 << m_row) : 0;
    chk("ERASE", 32'(ERASE), 32'(e_erase));
    chk("EXPOSE", 32'(EXPOSE), 32'(e_expose));
    chk("CONVERT", 32'(CONVERT), 32'(e_convert));
    chk("COUNTER", 32'(COUNTER), 32'(e_counter));
    chk("READ", 32'(READ), 32'(e_read));
    chk("busy", 32'(busy), 32'(m_busy));
    chk("frame_done", 32'(frame_done), 32'(m_fd));
    chk("out_valid", 32'(out_valid), 32'(m_ov));
    chk("out_data", 32'(out_data), 32'(m_od));
    chk("out_row", 32'(out_row), 32'(m_orow));
`ifdef PIXEL_CTRL_FRAME_CNT_EN
    chk("frame_count", 32'(frame_count), 32'(m_frames % 65536));
`endif
    if (frame_done) begin n_fd_seen++; fd_cyc = cyc; end
    if (EXPOSE) n_expose_seen++;
    if (ERASE && !prev_erase) erase_rise_cyc = cyc;
    prev_erase = ERASE;
  endtask

  // Accepted beats must come out of the slot in capture order with no loss.
  task automatic sb_check();
    logic [RW+DW-1:0] e;
    if (out_valid && out_ready && !reset) begin
      chk("sb_nonempty", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("sb_data", 32'(out_data), 32'(e[DW-1:0]));
        chk("sb_row", 32'(out_row), 32'(e[RW+DW-1:DW]));
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic cycle();
    sb_check();
    @(posedge clk);
    model_edge();
    cyc++;
    #1;
    check_outputs();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      if (rnd_ready) out_ready = 1'($urandom_range(0, 1));
      if (rnd_start) start = m_busy ? 1'($urandom_range(0, 1)) : 1'b0;
      cycle();
    end
  endtask

  task automatic run_until_idle(input int max_cycles, input string tag);
    int n;
    n = 0;
    while ((m_busy || m_ov) && n < max_cycles) begin
      run(1);
      n++;
    end
    start = 1'b0;
    chk(tag, 32'({busy, out_valid}), 32'd0);
  endtask

  task automatic start_frame();
    start = 1'b1;
    cycle();
    start = 1'b0;
  endtask

  task automatic randomize_pixels();
    for (int i = 0; i < H; i++) pix[i] = DW'($urandom);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int fd_before;
    for (int i = 0; i < H; i++) pix[i] = '0;
    model_reset();

    // Reset state
    reset = 1'b1;
    run(3);
    reset = 1'b0;
    run(2);

    // Single frame, E=10, no back-pressure
    for (int i = 0; i < H; i++) pix[i] = 16'hA55A;
    expose_time = 8'd10; out_ready = 1'b1; continuous = 1'b0;
    start_frame();
    run_until_idle(400, "single_idle");
    chk("single_len", 32'(fd_cyc - erase_rise_cyc), 32'(CE + 10 + CC + H * CRR));

    // Back-pressure: row 0 sits in the slot, row 1 must hold its select
    randomize_pixels();
    out_ready = 1'b0;
    start_frame();
    run(CE + 10 + CC + H * CRR + 20);
    chk("bp_read_hold", 32'(READ), 32'(1 << (H - 1)));
    chk("bp_row0_held", 32'({out_valid, out_row}), 32'({1'b1, RW'(0)}));
    out_ready = 1'b1;
    cycle();
    chk("bp_row1_capt", 32'({out_valid, out_row, frame_done}), 32'({1'b1, RW'(H - 1), 1'b1}));
    run_until_idle(50, "bp_idle");

    // Zero exposure: EXPOSE never asserted
    randomize_pixels();
    expose_time = 8'd0; n_expose_seen = 0;
    start_frame();
    run_until_idle(400, "e0_idle");
    chk("e0_no_expose", 32'(n_expose_seen), 32'd0);
    chk("e0_len", 32'(fd_cyc - erase_rise_cyc), 32'(CE + CC + H * CRR));

    // Continuous: frame 2 re-latches exposure, continuous dropped mid frame 2,
    // and start is toggled randomly while busy.
    randomize_pixels();
    expose_time = 8'd10; continuous = 1'b1;
    fd_before = n_fd_seen;
    start_frame();
    expose_time = 8'd7;
    rnd_start = 1;
    run(CE + 10 + CC + H * CRR + 50);
    continuous = 1'b0;
    run_until_idle(400, "cont_idle");
    rnd_start = 0;
    chk("cont_frames", 32'(n_fd_seen - fd_before), 32'd2);
    chk("cont_len2", 32'(fd_cyc - erase_rise_cyc), 32'(CE + 7 + CC + H * CRR));

    // Reset on CONVERT cycle 100 aborts without frame_done
    randomize_pixels();
    expose_time = 8'd10;
    start_frame();
    run(CE + 10 + 100);
    chk("rst_pre_counter", 32'(COUNTER), 32'd100);
    fd_before = n_fd_seen;
    reset = 1'b1;
    #1;
    model_reset();
    check_outputs();
    run(2);
    reset = 1'b0;
    run(20);
    chk("rst_no_fd", 32'(n_fd_seen - fd_before), 32'd0);
    start_frame();
    run_until_idle(400, "rst_full_idle");
    chk("rst_full_len", 32'(fd_cyc - erase_rise_cyc), 32'(CE + 10 + CC + H * CRR));

    // Random frames: random exposure, pixels and consumer back-pressure
    rnd_ready = 1;
    for (int f = 0; f < 4; f++) begin
      randomize_pixels();
      expose_time = EW'($urandom_range(0, 20));
      start_frame();
      run_until_idle(2000, "rnd_idle");
    end
    rnd_ready = 0;
    out_ready = 1'b1;
    run(3);
    chk("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
